z80_int_ctrl: RTL and testbench
===============================

# z80_int_ctrl

Eight-input vectored interrupt controller for the Z80 core. It sits beside the `z80` top-level and drives that block's `n_int` input. It consumes the registered bus outputs `n_m1`, `n_iorq`, `n_rd`, `n_wr`, `addr` and `dout`, and returns an IM2 vector or register read data onto the `din` mux. Scheme: fully nested priority with I/O-mapped mask, vector-base and end-of-interrupt (EOI) registers.

## Interface
- `BASE_PORT`, default `8'h40`: I/O port of the mask register. Registers live at `BASE_PORT+0..+2`.
- `RESET_MASK`, default `8'hFF`: mask value after reset (all sources masked).
- `clk`  in  1  single clock. All logic is on the rising edge.
- `n_reset`  in  1  reset, synchronous and active-low.
- `irq_in`  in  8  peripheral requests, synchronous to `clk`. A rising edge latches a request. Bit 0 has the highest priority.
- `n_m1`, `n_iorq`, `n_rd`, `n_wr`  in  1 each  Z80 bus strobes, active-low.
- `addr`  in  16  bus address. Only `addr[7:0]` is decoded.
- `dout`  in  8  CPU write data.
- `n_int`  out  1  interrupt request to the CPU, active-low, registered.
- `data_out`  out  8  vector or register read data.
- `data_out_en`  out  1  `data_out` is valid. The `din` mux selects this block when high.

## Operation
- Registers:
  - `pending[7:0]`: set on a rising edge of `irq_in[i]`.
  - `mask[7:0]` at `BASE_PORT`: R/W.
  - `vbase[7:0]` at `BASE_PORT+1`: R/W. Only `[7:4]` are used.
  - `in_service[7:0]`: readable at `BASE_PORT+2`. A write there is EOI (data ignored).
- Eligibility: `req = pending & ~mask`. Winner `id` is the lowest set bit of `req`. The winner is eligible only if no bit ≤ `id` is set in `in_service` (fully nested).
- State machine:
  - IDLE: `n_int=1`. Go to REQ when an eligible winner exists.
  - REQ: `n_int=0`. Go to ACK on the first cycle with `n_m1=0 && n_iorq=0`. Return to IDLE if eligibility vanishes (mask write).
  - ACK: on entry, freeze `id`, clear `pending[id]`, set `in_service[id]`. Drive `data_out={vbase[7:4], id, 1'b0}` and `data_out_en=1` while the ack strobes are held. Exit to IDLE when either strobe deasserts.
- An ack seen in IDLE (spurious) enters ACK with vector `{vbase[7:4],3'b111,1'b0}` and changes no state.
- I/O access: `n_iorq=0 && n_m1=1 && addr[7:0]` in range.
  - Write acts once, on the first cycle `n_wr` is sampled low.
  - Read drives `data_out`/`data_out_en` while `n_rd` is low.
  - Addresses outside the range are ignored and `data_out_en` stays 0.
- EOI clears the lowest set bit of `in_service`. EOI with `in_service=0` is a no-op.
- Simultaneous events:
  - A new `irq_in[i]` edge in the same cycle that ACK clears `pending[i]` leaves `pending[i]=1` (set wins).
  - A mask write in the same cycle as ack entry does not affect the frozen `id`.
- Masked requests stay pending and fire on unmask.
- Reset mid-ACK: all state clears; outputs take reset values next cycle.

## Timing
- Reset values: `n_int=1`, `data_out=8'h00`, `data_out_en=0`, `pending=0`, `in_service=0`, `mask=RESET_MASK`, `vbase=8'h00`, state IDLE.
- `irq_in` edge first sampled high at cycle t:
  - `pending` set at t+1.
  - `n_int` low at t+2, if eligible and unmasked.
- Ack first sampled at cycle a:
  - `data_out_en=1` and vector valid from a+1.
  - `n_int=1` from a+1.
  - `data_out_en=0` the cycle after the strobes are sampled high.
- Register write first sampled at cycle w: new value visible at w+1, affecting `n_int` at w+2.
- Read data valid one cycle after `n_rd` is sampled low, and held while low.

## Structure
- Package `z80_pkg` holds:
  - offsets `INTC_MASK=0`, `INTC_VBASE=1`, `INTC_EOI=2`;
  - state enum IDLE/REQ/ACK;
  - spurious id `3'b111`.
- Sub-module `z80_int_prio`: combinational 8-bit priority encoder with the in-service nesting check. Outputs `valid` and `id[2:0]`.

## Test plan
- Reset, then write `mask=8'h00` and `vbase=8'hA0`. Pulse `irq_in[3]`. Expected: `n_int` low 2 cycles after the edge. Ack gives `data_out=8'hA6` with `data_out_en=1`; `in_service=8'h08`.
- With `in_service[3]` set, pulse `irq_in[5]`. Expected: `n_int` stays high. After EOI, `n_int` goes low and the ack vector is `8'hAA`.
- Pulse `irq_in[2]` and `irq_in[6]` in the same cycle. Expected: first ack gives `8'hA4`. After EOI, second ack gives `8'hAC`.
- Keep `mask=8'hFF` and pulse `irq_in[0]`. Expected: `n_int` stays high and the mask read returns `8'hFF`. Write `mask=8'hFE`. Expected: `n_int` low 2 cycles later.
- Ack while IDLE. Expected: vector `8'hAE`, and pending/in_service unchanged.
- Assert `n_reset` low during ACK. Expected: next cycle `data_out_en=0`, `n_int=1`, and mask reads `8'hFF`.

Source files
------------

// File: rtl/z80_int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// z80_pkg
// Shared definitions for the Z80 vectored interrupt controller: register
// offsets relative to the controller's base I/O port, the acknowledge state
// machine encoding, the vector used for spurious acknowledges, and the helper
// that builds an IM2 vector.
// -----------------------------------------------------------------------------
package z80_pkg;

   // Register offsets from BASE_PORT
   localparam logic [7:0] INTC_MASK  = 8'd0;  // R/W source mask, 1 = masked
   localparam logic [7:0] INTC_VBASE = 8'd1;  // R/W vector base, [7:4] used
   localparam logic [7:0] INTC_EOI   = 8'd2;  // R: in-service, W: end-of-interrupt

   // Source id reported when the CPU acknowledges with nothing requested
   localparam logic [2:0] SPURIOUS_ID = 3'b111;

   // Interrupt handshake state
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // n_int released, waiting for an eligible source
      REQ  = 2'd1,   // n_int asserted, waiting for the CPU acknowledge
      ACK  = 2'd2    // acknowledge cycle, vector on data_out
   } intc_state_e;

   // IM2 vector: vector base high nibble, source id, even address
   function automatic logic [7:0] intc_vector(input logic [7:0] vbase,
                                              input logic [2:0] id);
      return {vbase[7:4], id, 1'b0};
   endfunction

endpackage : z80_pkg

// File: rtl/z80_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// z80_int_ctrl_if
// Bus connection between the Z80 core (master) and the interrupt controller
// (slave).
//   n_m1, n_iorq, n_rd, n_wr  CPU strobes, active-low (master -> slave)
//   addr[15:0]                CPU address, low byte decoded   (master -> slave)
//   dout[7:0]                 CPU write data                  (master -> slave)
//   n_int                     interrupt request, active-low   (slave -> master)
//   data_out[7:0]             vector or register read data    (slave -> master)
//   data_out_en               data_out valid / din mux select (slave -> master)
// -----------------------------------------------------------------------------
interface z80_int_ctrl_if;

   logic        n_m1;
   logic        n_iorq;
   logic        n_rd;
   logic        n_wr;
   logic [15:0] addr;
   logic [7:0]  dout;

   logic        n_int;
   logic [7:0]  data_out;
   logic        data_out_en;

   modport master (
      output n_m1, n_iorq, n_rd, n_wr, addr, dout,
      input  n_int, data_out, data_out_en
   );

   modport slave (
      input  n_m1, n_iorq, n_rd, n_wr, addr, dout,
      output n_int, data_out, data_out_en
   );

endinterface : z80_int_ctrl_if

// File: rtl/z80_int_prio.sv
// -----------------------------------------------------------------------------
// z80_int_prio
// Combinational priority resolver for eight interrupt sources with fully
// nested in-service blocking. Bit 0 is the highest priority.
//   pending[7:0]     latched requests
//   mask[7:0]        1 = source masked
//   in_service[7:0]  sources whose handlers are currently running
//   valid            a winner exists and is not blocked by in-service
//   id[2:0]          winning source (lowest unmasked pending bit)
// -----------------------------------------------------------------------------
module z80_int_prio
   import z80_pkg::*;
(
   input  logic [7:0] pending,
   input  logic [7:0] mask,
   input  logic [7:0] in_service,
   output logic       valid,
   output logic [2:0] id
);

   logic [7:0] req;
   logic       found;
   logic       blocked;

   // NOTE: every variable driven here gets a default before any condition,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      req     = pending & ~mask;
      id      = 3'd0;
      found   = 1'b0;
      blocked = 1'b0;

      // Scan downwards so the lowest set bit is the last one written
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            id    = 3'(i);
            found = 1'b1;
         end
      end

      // Fully nested: a running handler of equal or higher priority blocks.
      // Any other request has a larger id, so it is blocked as well.
      for (int i = 0; i < 8; i++) begin
         if (in_service[i] && (i <= int'(id))) begin
            blocked = 1'b1;
         end
      end

      valid = found && !blocked;
   end

endmodule : z80_int_prio

// File: rtl/z80_int_ctrl.sv
// -----------------------------------------------------------------------------
// z80_int_ctrl
// Eight-input vectored interrupt controller for the Z80 (IM2). Latches rising
// edges of irq_in, resolves the highest-priority eligible source, drives n_int
// and answers the interrupt acknowledge cycle with
// {vbase[7:4], id, 1'b0}. Mask, vector base and in-service/EOI registers are
// I/O mapped at BASE_PORT+0..+2.
//   clk         single rising-edge clock
//   n_reset     synchronous active-low reset
//   irq_in[7:0] peripheral requests, rising edge latches, bit 0 highest
//   bus         z80_int_ctrl_if.slave: CPU strobes/address/data in,
//               n_int, data_out, data_out_en out (all registered)
// Parameters:
//   BASE_PORT   I/O port of the mask register
//   RESET_MASK  mask value after reset
// -----------------------------------------------------------------------------
module z80_int_ctrl
   import z80_pkg::*;
#(
   parameter logic [7:0] BASE_PORT  = 8'h40,
   parameter logic [7:0] RESET_MASK = 8'hFF
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic [7:0]         irq_in,
   z80_int_ctrl_if.slave      bus
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   intc_state_e state, state_next;

   logic [7:0] pending,    pending_next;
   logic [7:0] mask,       mask_next;
   logic [7:0] vbase,      vbase_next;
   logic [7:0] in_service, in_service_next;
   logic [7:0] irq_q;
   logic       wr_act_q;

   logic       n_int_q,       n_int_next;
   logic [7:0] data_out_q,    data_out_next;
   logic       data_out_en_q, data_out_en_next;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic       ack;
   logic [7:0] offset;
   logic       io_sel;
   logic       wr_act;
   logic       wr_pulse;
   logic       rd_act;
   logic [7:0] irq_rise;
   logic       unused_addr_hi;

   // Only the low address byte is decoded, as on a standard Z80 I/O map
   assign unused_addr_hi = ^bus.addr[15:8];

   // M1 together with IORQ is the interrupt acknowledge cycle
   assign ack    = !bus.n_m1 && !bus.n_iorq;

   assign offset = bus.addr[7:0] - BASE_PORT;
   assign io_sel = !bus.n_iorq && bus.n_m1 && (offset <= INTC_EOI);

   // A write strobe may be held for several clocks; act only on the first
   assign wr_act   = io_sel && !bus.n_wr;
   assign wr_pulse = wr_act && !wr_act_q;
   assign rd_act   = io_sel && !bus.n_rd;

   assign irq_rise = irq_in & ~irq_q;

   // ---------------------------------------------------------------------------
   // Priority resolution
   // ---------------------------------------------------------------------------
   logic       prio_valid;
   logic [2:0] prio_id;

   z80_int_prio u_prio (
      .pending    (pending),
      .mask       (mask),
      .in_service (in_service),
      .valid      (prio_valid),
      .id         (prio_id)
   );

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   logic ack_entry;  // entering ACK this cycle (real or spurious)
   logic ack_real;   // entering ACK with a genuine winner

   always_comb begin
      state_next = state;
      ack_entry  = 1'b0;
      ack_real   = 1'b0;

      unique case (state)
         IDLE: begin
            // An acknowledge without a request is spurious
            if (ack) begin
               state_next = ACK;
               ack_entry  = 1'b1;
            end else if (prio_valid) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (ack) begin
               state_next = ACK;
               ack_entry  = 1'b1;
               ack_real   = prio_valid;
            end else if (!prio_valid) begin
               // Request withdrawn, typically by a mask write
               state_next = IDLE;
            end
         end
         ACK: begin
            if (!ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register and output next values
   // ---------------------------------------------------------------------------
   logic [7:0] ack_vector;
   logic [7:0] rd_data;

   always_comb begin
      pending_next     = pending;
      mask_next        = mask;
      vbase_next       = vbase;
      in_service_next  = in_service;
      ack_vector       = intc_vector(vbase, ack_real ? prio_id : SPURIOUS_ID);
      rd_data          = 8'h00;
      data_out_next    = data_out_q;
      data_out_en_next = 1'b0;
      n_int_next       = 1'b1;

      // Acknowledge moves the winner from pending to in-service; the id used
      // here is the one resolved in the entry cycle and is never revisited.
      if (ack_real) begin
         pending_next[prio_id]    = 1'b0;
         in_service_next[prio_id] = 1'b1;
      end
      // A new edge in the same cycle as the clear keeps the request
      pending_next = pending_next | irq_rise;

      if (wr_pulse) begin
         case (offset)
            INTC_MASK:  mask_next  = bus.dout;
            INTC_VBASE: vbase_next = bus.dout;
            // EOI retires the highest-priority running handler; x & (x-1)
            // clears the lowest set bit and leaves zero unchanged.
            INTC_EOI:   in_service_next = in_service & (in_service - 8'd1);
            default:    ;
         endcase
      end

      case (offset)
         INTC_MASK:  rd_data = mask;
         INTC_VBASE: rd_data = vbase;
         INTC_EOI:   rd_data = in_service;
         default:    rd_data = 8'h00;
      endcase

      // Vector is captured once on entry and held for the whole ACK
      if (ack_entry) begin
         data_out_next = ack_vector;
      end else if (rd_act) begin
         data_out_next = rd_data;
      end

      data_out_en_next = (state_next == ACK) || rd_act;
      n_int_next       = (state_next != REQ);
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   // NOTE: reset is sampled on the clock edge only, so it appears inside the
   // clocked block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state         <= IDLE;
         pending       <= 8'h00;
         mask          <= RESET_MASK;
         vbase         <= 8'h00;
         in_service    <= 8'h00;
         irq_q         <= 8'h00;
         wr_act_q      <= 1'b0;
         n_int_q       <= 1'b1;
         data_out_q    <= 8'h00;
         data_out_en_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the values
         // from before the edge, independent of statement order.
         state         <= state_next;
         pending       <= pending_next;
         mask          <= mask_next;
         vbase         <= vbase_next;
         in_service    <= in_service_next;
         irq_q         <= irq_in;
         wr_act_q      <= wr_act;
         n_int_q       <= n_int_next;
         data_out_q    <= data_out_next;
         data_out_en_q <= data_out_en_next;
      end
   end

   assign bus.n_int       = n_int_q;
   assign bus.data_out    = data_out_q;
   assign bus.data_out_en = data_out_en_q;

endmodule : z80_int_ctrl

// File: tb/tb_z80_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z80_int_ctrl
// Directed bench for z80_int_ctrl. Stimulus tasks push the expected vector or
// read data into a scoreboard queue; a monitor on the falling clock edge pops
// and compares whenever data_out_en rises. Handshake timing is checked
// directly with check().
// -----------------------------------------------------------------------------
module tb_z80_int_ctrl;

   localparam logic [7:0] BASE = 8'h40;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [7:0] irq_in;

   z80_int_ctrl_if bus ();

   z80_int_ctrl #(
      .BASE_PORT  (BASE),
      .RESET_MASK (8'hFF)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .irq_in  (irq_in),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [7:0] sb_data[$];
   string      sb_name[$];

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.n_m1   = 1'b1;
      bus.n_iorq = 1'b1;
      bus.n_rd   = 1'b1;
      bus.n_wr   = 1'b1;
      bus.addr   = 16'h0000;
      bus.dout   = 8'h00;
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      bus.addr   = {8'h12, a};
      bus.dout   = d;
      bus.n_iorq = 1'b0;
      bus.n_wr   = 1'b0;
      tick();
      tick();
      bus_idle();
      tick();
   endtask

   task automatic io_read(input logic [7:0] a, input logic [7:0] exp,
                          input string name);
      sb_data.push_back(exp);
      sb_name.push_back(name);
      bus.addr   = {8'h34, a};
      bus.n_iorq = 1'b0;
      bus.n_rd   = 1'b0;
      repeat (3) tick();
      bus_idle();
      tick();
      tick();
   endtask

   task automatic ack_cycle(input logic [7:0] exp, input string name);
      sb_data.push_back(exp);
      sb_name.push_back(name);
      bus.n_m1   = 1'b0;
      bus.n_iorq = 1'b0;
      tick();
      check({name, "_n_int"}, 32'(bus.n_int), 32'd1);
      tick();
      tick();
      bus_idle();
      tick();
      check({name, "_en_off"}, 32'(bus.data_out_en), 32'd0);
      tick();
   endtask

   // One-cycle request pulse; returns just after the edge that sampled it
   task automatic pulse(input logic [7:0] bits);
      irq_in = bits;
      tick();
      irq_in = 8'h00;
   endtask

   task automatic wait_n_int(input logic lvl, input int max_cycles,
                             input string name);
      for (int i = 0; i < max_cycles && bus.n_int !== lvl; i++) tick();
      check(name, 32'(bus.n_int), 32'(lvl));
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   logic en_q = 1'b0;

   always @(negedge clk) begin
      if (bus.data_out_en && !en_q) begin
         n_compared++;
         if (sb_data.size() == 0) begin
            n_mismatched++;
            $display("FAIL sb_unexpected: data_out=%0h with nothing expected at %0t",
                     bus.data_out, $time);
         end else begin
            logic [7:0] exp;
            string      name;
            exp  = sb_data.pop_front();
            name = sb_name.pop_front();
            if (bus.data_out !== exp) begin
               n_mismatched++;
               $display("FAIL %s: data_out=%0h expected %0h at %0t",
                        name, bus.data_out, exp, $time);
            end
         end
      end
      en_q = bus.data_out_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      n_reset = 1'b0;
      irq_in  = 8'h00;
      bus_idle();
      repeat (3) tick();
      check("rst_n_int",  32'(bus.n_int),       32'd1);
      check("rst_en",     32'(bus.data_out_en), 32'd0);
      check("rst_dout",   32'(bus.data_out),    32'h00);
      n_reset = 1'b1;
      tick();

      io_read(BASE + 8'd0, 8'hFF, "rd_mask_rst");
      io_read(BASE + 8'd1, 8'h00, "rd_vbase_rst");
      io_read(BASE + 8'd2, 8'h00, "rd_isr_rst");
      io_write(BASE + 8'd0, 8'h00);
      io_write(BASE + 8'd1, 8'hA0);
      io_read(BASE + 8'd1, 8'hA0, "rd_vbase");

      // Single source: n_int low two edges after the request is sampled
      pulse(8'h08);
      check("irq3_n_int_t1", 32'(bus.n_int), 32'd1);
      tick();
      check("irq3_n_int_t2", 32'(bus.n_int), 32'd0);
      ack_cycle(8'hA6, "ack_irq3");
      io_read(BASE + 8'd2, 8'h08, "isr_irq3");

      // Lower priority blocked by running handler until EOI
      pulse(8'h20);
      repeat (4) tick();
      check("irq5_blocked", 32'(bus.n_int), 32'd1);
      io_write(BASE + 8'd2, 8'h00);
      check("irq5_after_eoi", 32'(bus.n_int), 32'd0);
      ack_cycle(8'hAA, "ack_irq5");
      io_write(BASE + 8'd2, 8'h00);
      io_read(BASE + 8'd2, 8'h00, "isr_clear_5");

      // Simultaneous requests: priority, then nesting, then preemption
      pulse(8'h44);
      wait_n_int(1'b0, 4, "irq26_req");
      ack_cycle(8'hA4, "ack_irq2");
      repeat (4) tick();
      check("irq6_nested_block", 32'(bus.n_int), 32'd1);
      io_write(BASE + 8'd2, 8'h00);
      check("irq6_after_eoi", 32'(bus.n_int), 32'd0);
      ack_cycle(8'hAC, "ack_irq6");
      io_read(BASE + 8'd2, 8'h40, "isr_6");
      pulse(8'h02);
      wait_n_int(1'b0, 4, "irq1_preempt");
      ack_cycle(8'hA2, "ack_irq1");
      io_read(BASE + 8'd2, 8'h42, "isr_1_6");
      io_write(BASE + 8'd2, 8'h00);
      io_read(BASE + 8'd2, 8'h40, "isr_eoi_once");
      io_write(BASE + 8'd2, 8'h00);
      io_read(BASE + 8'd2, 8'h00, "isr_clear_6");
      io_write(BASE + 8'd2, 8'h00);
      io_read(BASE + 8'd2, 8'h00, "isr_eoi_noop");

      // Masked request waits, fires on unmask
      io_write(BASE + 8'd0, 8'hFF);
      pulse(8'h01);
      repeat (4) tick();
      check("irq0_masked", 32'(bus.n_int), 32'd1);
      io_read(BASE + 8'd0, 8'hFF, "rd_mask_ff");
      io_write(BASE + 8'd0, 8'hFE);
      check("irq0_unmasked", 32'(bus.n_int), 32'd0);
      ack_cycle(8'hA0, "ack_irq0");
      io_write(BASE + 8'd2, 8'h00);

      // Spurious ack with a masked request pending: nothing changes
      io_write(BASE + 8'd0, 8'hFF);
      pulse(8'h10);
      repeat (3) tick();
      check("irq4_masked", 32'(bus.n_int), 32'd1);
      ack_cycle(8'hAE, "ack_spurious");
      io_read(BASE + 8'd2, 8'h00, "isr_spurious");
      io_write(BASE + 8'd0, 8'h00);
      check("irq4_kept", 32'(bus.n_int), 32'd0);
      ack_cycle(8'hA8, "ack_irq4");
      io_write(BASE + 8'd2, 8'h00);

      // Out-of-range I/O reads must not drive the bus
      bus.addr   = {8'h00, BASE + 8'd3};
      bus.n_iorq = 1'b0;
      bus.n_rd   = 1'b0;
      repeat (2) tick();
      check("oor_hi_en", 32'(bus.data_out_en), 32'd0);
      bus.addr = {8'h00, BASE - 8'd1};
      repeat (2) tick();
      check("oor_lo_en", 32'(bus.data_out_en), 32'd0);
      bus_idle();
      tick();

      // Reset in the middle of an acknowledge
      pulse(8'h40);
      wait_n_int(1'b0, 4, "irq6_req_rst");
      sb_data.push_back(8'hAC);
      sb_name.push_back("ack_before_rst");
      bus.n_m1   = 1'b0;
      bus.n_iorq = 1'b0;
      tick();
      check("ack_rst_en_on", 32'(bus.data_out_en), 32'd1);
      n_reset = 1'b0;
      tick();
      check("rst_mid_ack_en",    32'(bus.data_out_en), 32'd0);
      check("rst_mid_ack_n_int", 32'(bus.n_int),       32'd1);
      bus_idle();
      n_reset = 1'b1;
      tick();
      io_read(BASE + 8'd0, 8'hFF, "mask_after_rst");
      io_read(BASE + 8'd2, 8'h00, "isr_after_rst");
      io_read(BASE + 8'd1, 8'h00, "vbase_after_rst");

      repeat (3) tick();
      check("sb_drain", 32'(sb_data.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_z80_int_ctrl
